// File: rtl/mem_arb.sv
// Shares one memory port between IFU fetches and LSU loads/stores.
// Round-robin arbitration, LSU byte-mask/alignment checks, per-access timeout.
module mem_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 16,
   parameter int RESET_PRIO = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ifu_req,
   input  logic [ADDR_W-1:0] i_ifu_addr,
   output logic              o_ifu_gnt,
   output logic              o_ifu_rvalid,
   output logic [DATA_W-1:0] o_ifu_rdata,
   output logic              o_ifu_err,
   input  logic              i_lsu_req,
   input  logic              i_lsu_wen,
   input  logic [1:0]        i_lsu_size,
   input  logic [ADDR_W-1:0] i_lsu_addr,
   input  logic [DATA_W-1:0] i_lsu_wdata,
   output logic              o_lsu_gnt,
   output logic              o_lsu_rvalid,
   output logic [DATA_W-1:0] o_lsu_rdata,
   output logic              o_lsu_err,
   output logic              o_mem_valid,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [3:0]        o_mem_wmask,
   input  logic              i_mem_ready,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   // state  | meaning
   // IDLE   | arbitrate; grant and latch a request, or answer a bad one
   // REQ    | o_mem_valid high, waiting for i_mem_ready
   // RESP   | waiting for i_mem_rvalid
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   localparam int CNT_W = 16;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ifu_rvalid_q, ifu_rvalid_d, ifu_err_q, ifu_err_d;
   logic              lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
   logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

   logic              sel_ifu, sel_lsu, ifu_bad, lsu_bad, timeout_hit;
   logic              resp_fire, resp_lsu, resp_err;
   logic [DATA_W-1:0] resp_data;
   logic [3:0]        lsu_mask;

   assign sel_ifu = i_ifu_req & (~i_lsu_req | ~prio_q);
   assign sel_lsu = i_lsu_req & (~i_ifu_req | prio_q);
   assign ifu_bad = |i_ifu_addr[1:0];
   assign lsu_bad = (i_lsu_size == 2'd3)
                  | ((i_lsu_size == 2'd1) & i_lsu_addr[0])
                  | ((i_lsu_size == 2'd2) & (|i_lsu_addr[1:0]));
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         prio_q       <= 1'(RESET_PRIO);
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         cnt_q        <= '0;
         ifu_rvalid_q <= 1'b0;
         ifu_err_q    <= 1'b0;
         ifu_rdata_q  <= '0;
         lsu_rvalid_q <= 1'b0;
         lsu_err_q    <= 1'b0;
         lsu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         cnt_q        <= cnt_d;
         ifu_rvalid_q <= ifu_rvalid_d;
         ifu_err_q    <= ifu_err_d;
         ifu_rdata_q  <= ifu_rdata_d;
         lsu_rvalid_q <= lsu_rvalid_d;
         lsu_err_q    <= lsu_err_d;
         lsu_rdata_q  <= lsu_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      cnt_d        = cnt_q;
      resp_fire    = 1'b0;
      resp_lsu     = owner_q;
      resp_err     = 1'b0;
      resp_data    = '0;
      ifu_rvalid_d = 1'b0;
      ifu_err_d    = 1'b0;
      ifu_rdata_d  = ifu_rdata_q;
      lsu_rvalid_d = 1'b0;
      lsu_err_d    = 1'b0;
      lsu_rdata_d  = lsu_rdata_q;
      case (i_lsu_size)
         2'd0:    lsu_mask = 4'b0001 << i_lsu_addr[1:0];
         2'd1:    lsu_mask = 4'b0011 << i_lsu_addr[1:0];
         default: lsu_mask = 4'b1111;
      endcase
      case (state_q)
         S_IDLE: begin
            if (sel_ifu || sel_lsu) begin
               prio_d   = sel_ifu;
               owner_d  = sel_lsu;
               resp_lsu = sel_lsu;
               cnt_d    = '0;
               if (sel_ifu) begin
                  addr_d  = {i_ifu_addr[ADDR_W-1:2], 2'b00};
                  wen_d   = 1'b0;
                  wdata_d = '0;
                  wmask_d = '0;
               end else begin
                  addr_d  = {i_lsu_addr[ADDR_W-1:2], 2'b00};
                  wen_d   = i_lsu_wen;
                  wdata_d = i_lsu_wdata;
                  wmask_d = i_lsu_wen ? lsu_mask : 4'b0000;
               end
               // Bad requests are answered directly without touching memory
               if ((sel_ifu && ifu_bad) || (sel_lsu && lsu_bad)) begin
                  resp_fire = 1'b1;
                  resp_err  = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (timeout_hit) begin
               resp_fire = 1'b1;
               resp_err  = 1'b1;
               state_d   = S_IDLE;
            end else if (i_mem_ready) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d = cnt_q + 1'b1;
            if (i_mem_rvalid) begin
               resp_fire = 1'b1;
               resp_data = wen_q ? '0 : i_mem_rdata;
               state_d   = S_IDLE;
            end else if (timeout_hit) begin
               resp_fire = 1'b1;
               resp_err  = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (resp_fire) begin
         if (resp_lsu) begin
            lsu_rvalid_d = 1'b1;
            lsu_err_d    = resp_err;
            lsu_rdata_d  = resp_data;
         end else begin
            ifu_rvalid_d = 1'b1;
            ifu_err_d    = resp_err;
            ifu_rdata_d  = resp_data;
         end
      end
   end

   // Grants are gated by reset so every output is low while reset is asserted
   always_comb begin
      o_ifu_gnt   = i_rst_n & (state_q == S_IDLE) & sel_ifu;
      o_lsu_gnt   = i_rst_n & (state_q == S_IDLE) & sel_lsu;
      o_mem_valid = (state_q == S_REQ);
   end

   assign o_mem_wen    = wen_q;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;
   assign o_mem_wmask  = wmask_q;
   assign o_ifu_rvalid = ifu_rvalid_q;
   assign o_ifu_err    = ifu_err_q;
   assign o_ifu_rdata  = ifu_rdata_q;
   assign o_lsu_rvalid = lsu_rvalid_q;
   assign o_lsu_err    = lsu_err_q;
   assign o_lsu_rdata  = lsu_rdata_q;

endmodule
